ice_rr_tx_arbiter: RTL and testbench

//  Round-robin, packet-locked arbiter sharing the single UART TX path among NUM_DEV slave

---
 rtl/ice_rr_tx_arbiter_pkg.sv | 11 +
 rtl/ice_rr_tx_arbiter_pick.sv | 55 +++++
 rtl/ice_rr_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_ice_rr_tx_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ice_rr_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART TX arbiter.
// The state encodings are fixed so the TX FSM debug view can decode them directly.
package ice_rr_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_HOLDOFF = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ice_rr_tx_arbiter_pick.sv
// Combinational round-robin pick: rotate the eligible vector so the search starts
// just after last_ptr, priority-encode the rotated vector, then map back to an index.
module ice_rr_tx_arbiter_pick
  import ice_rr_tx_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_DEV-1:0] eligible,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_DEV-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [IDX_W-1:0]   start;
  logic [NUM_DEV-1:0] rot;
  logic [IDX_W-1:0]   offset;
  logic               found;
  int unsigned        src;
  int unsigned        sum;

  always_comb begin
    start = (last_ptr == IDX_W'(NUM_DEV - 1)) ? '0 : last_ptr + 1'b1;

    rot = '0;
    src = 0;
    for (int j = 0; j < NUM_DEV; j++) begin
      src = int'(start) + j;
      if (src >= NUM_DEV) src = src - NUM_DEV;
      rot[j] = eligible[src];
    end

    // Lowest set bit of the rotated vector is the nearest requester after last_ptr.
    found  = 1'b0;
    offset = '0;
    for (int j = 0; j < NUM_DEV; j++) begin
      if (rot[j] && !found) begin
        found  = 1'b1;
        offset = IDX_W'(j);
      end
    end

    sum = int'(start) + int'(offset);
    if (sum >= NUM_DEV) sum = sum - NUM_DEV;

    pick_valid  = found;
    pick_idx    = IDX_W'(sum);
    pick_onehot = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      pick_onehot[i] = found && (sum == i);
    end
  end

endmodule

// File: rtl/ice_rr_tx_arbiter.sv
// Round-robin, packet-locked arbiter for the shared UART TX path. A grant is held for a
// whole packet, followed by a one-cycle holdoff; a watchdog revokes and locks out hung owners.
module ice_rr_tx_arbiter
  import ice_rr_tx_arbiter_pkg::*;
#(
  parameter int               NUM_DEV = 2,
  parameter int               IDX_W   = 1,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_DEV-1:0] requests,
  input  logic               pkt_done,
  output logic [NUM_DEV-1:0] grants,
  output logic               granted,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout_evt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - 1'b1;
  localparam logic             WD_EN    = (TIMEOUT != '0);

  arb_state_e         state_q, state_d;
  logic [NUM_DEV-1:0] grants_q, grants_d;
  logic               granted_q, granted_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               timeout_evt_q, timeout_evt_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [NUM_DEV-1:0] lockout_q, lockout_d;
  logic [TMO_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic [NUM_DEV-1:0] eligible;
  logic [NUM_DEV-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  assign eligible = requests & ~lockout_q;

  ice_rr_tx_arbiter_pick #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible    (eligible),
    .last_ptr    (last_ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    grants_d      = grants_q;
    grant_idx_d   = grant_idx_q;
    timeout_evt_d = 1'b0;
    last_ptr_d    = last_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    // A locked-out requester is forgiven as soon as it drops its request.
    lockout_d     = lockout_q & requests;

    unique case (state_q)
      ARB_IDLE: begin
        if (enable && pick_valid) begin
          grants_d    = pick_onehot;
          grant_idx_d = pick_idx;
          last_ptr_d  = pick_idx;
          wd_cnt_d    = '0;
          state_d     = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        if (pkt_done || !requests[grant_idx_q]) begin
          grants_d = '0;
          state_d  = ARB_HOLDOFF;
        end else if (WD_EN && (wd_cnt_q == TMO_LAST)) begin
          grants_d                 = '0;
          timeout_evt_d            = 1'b1;
          lockout_d[grant_idx_q]   = 1'b1;
          state_d                  = ARB_HOLDOFF;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      ARB_HOLDOFF: begin
        grants_d = '0;
        state_d  = ARB_IDLE;
      end

      default: begin
        grants_d = '0;
        state_d  = ARB_IDLE;
      end
    endcase

    granted_d = |grants_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grants_q      <= '0;
      granted_q     <= 1'b0;
      grant_idx_q   <= '0;
      timeout_evt_q <= 1'b0;
      last_ptr_q    <= IDX_W'(NUM_DEV - 1);
      lockout_q     <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      grants_q      <= grants_d;
      granted_q     <= granted_d;
      grant_idx_q   <= grant_idx_d;
      timeout_evt_q <= timeout_evt_d;
      last_ptr_q    <= last_ptr_d;
      lockout_q     <= lockout_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign grants      = grants_q;
  assign granted     = granted_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_ice_rr_tx_arbiter.sv
// Randomized bench for ice_rr_tx_arbiter with a cycle-level reference model of the
// arbitration rules, plus short directed scenarios for fairness, watchdog and enable.
module tb_ice_rr_tx_arbiter;

  localparam int          N   = 3;
  localparam int          TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] requests;
  logic         pkt_done;
  logic [N-1:0] grants;
  logic         granted;
  logic [1:0]   grant_idx;
  logic         timeout_evt;

  int numCompared   = 0;
  int numMismatched = 0;

  // Reference model: who owns the bus, whether we are in the post-release gap,
  // who was served last, and which requesters are barred after a watchdog hit.
  int mOwner;
  int mLast;
  int mLastIdx;
  int mAge;
  bit mHold;
  bit mEvt;
  bit mLocked [N];

  always #5 clk = ~clk;

  ice_rr_tx_arbiter #(
    .NUM_DEV (N),
    .IDX_W   (2),
    .TMO_W   (16),
    .TIMEOUT (16'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .requests    (requests),
    .pkt_done    (pkt_done),
    .grants      (grants),
    .granted     (granted),
    .grant_idx   (grant_idx),
    .timeout_evt (timeout_evt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit nl [N];
    int c;
    mEvt = 1'b0;
    if (rst) begin
      mOwner = -1;
      mHold = 1'b0;
      mLast = N - 1;
      mLastIdx = 0;
      mAge = 0;
      for (int i = 0; i < N; i++) mLocked[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) nl[i] = mLocked[i] && requests[i];
      if (mOwner >= 0) begin
        if (pkt_done || !requests[mOwner]) begin
          mOwner = -1;
          mHold = 1'b1;
        end else if (TMO != 0 && mAge == TMO - 1) begin
          mEvt = 1'b1;
          nl[mOwner] = 1'b1;
          mOwner = -1;
          mHold = 1'b1;
        end else if (mAge < 65535) begin
          mAge++;
        end
      end else if (mHold) begin
        mHold = 1'b0;
      end else if (enable) begin
        for (int k = 1; k <= N; k++) begin
          c = (mLast + k) % N;
          if (mOwner < 0 && requests[c] && !mLocked[c]) begin
            mOwner = c;
            mLastIdx = c;
            mAge = 0;
          end
        end
        if (mOwner >= 0) mLast = mOwner;
      end
      for (int i = 0; i < N; i++) mLocked[i] = nl[i];
    end
  endtask

  task automatic compareAll();
    logic [31:0] expGrants;
    expGrants = (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
    checkOutput("grants", 32'(grants), expGrants);
    checkOutput("granted", 32'(granted), (mOwner >= 0) ? 32'd1 : 32'd0);
    checkOutput("grant_idx", 32'(grant_idx), 32'(mLastIdx));
    checkOutput("timeout_evt", 32'(timeout_evt), 32'(mEvt));
  endtask

  // Inputs change just after a falling edge, are sampled on the rising edge,
  // and outputs are compared on the following falling edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [N-1:0] req, input logic done);
    rst      = r;
    enable   = en;
    requests = req;
    pkt_done = done;
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    int          order [$];
    logic [N-1:0] prevGrants;
    logic [N-1:0] reqs;
    int          evtCount;

    rst = 1'b1; enable = 1'b0; requests = '0; pkt_done = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b111, 1'b1);
    checkOutput("rst_grants", 32'(grants), 32'd0);
    checkOutput("rst_idx", 32'(grant_idx), 32'd0);
    checkOutput("rst_evt", 32'(timeout_evt), 32'd0);

    // All requesting: first grant goes to 0, then strict rotation
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b0);
    checkOutput("first_after_rst", 32'(grants), 32'd1);
    prevGrants = grants;
    order.push_back(int'(grant_idx));
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b0, 1'b1, 3'b111, (n % 4) == 3);
      if (grants != '0 && prevGrants == '0) order.push_back(int'(grant_idx));
      prevGrants = grants;
    end
    checkOutput("fair_count", 32'(order.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      checkOutput("fair_order", 32'(order[i]), 32'(i % N));
    end

    // Watchdog: req0 held with no pkt_done is revoked once and locked out
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0);
    evtCount = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
      if (timeout_evt) evtCount++;
    end
    checkOutput("tmo_pulses", 32'(evtCount), 32'd1);
    checkOutput("lock_nogrant", 32'(granted), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    checkOutput("unlock_grant", 32'(grants), 32'd1);

    // Enable gating: no new grant while low, existing grant unaffected
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b0, 3'b010, 1'b0);
    checkOutput("en_off_idle", 32'(grants), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    checkOutput("en_on_grant", 32'(grants), 32'd2);
    for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0, 3'b010, 1'b0);
    checkOutput("en_off_hold", 32'(grants), 32'd2);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b1);
    checkOutput("done_release", 32'(grants), 32'd0);

    // Mid-packet reset drops the grant immediately
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    checkOutput("rst_mid_grants", 32'(grants), 32'd0);
    checkOutput("rst_mid_idx", 32'(grant_idx), 32'd0);

    // Randomized traffic against the model
    reqs = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (reqs[i]) begin
          if ($urandom_range(0, 9) == 0) reqs[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) reqs[i] = 1'b1;
        end
      end
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                    reqs, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
